// File: rtl/feedback_accum_pkg.sv
// feedback_accum_pkg: shared helpers for the multi-channel feedback accumulator.
package feedback_accum_pkg;

    function automatic int chan_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // Clamp bounds as bit patterns; callers truncate to their accumulator width.
    function automatic logic [31:0] sat_max(input int acc_w);
        return (32'd1 << (acc_w - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] sat_min(input int acc_w);
        return ~sat_max(acc_w);
    endfunction

endpackage

// File: rtl/feedback_accum_step.sv
// feedback_accum_step: one combinational accumulator update (leak, add, wrap or clamp).
module feedback_accum_step
    import feedback_accum_pkg::*;
#(
    parameter int IN_W       = 8,
    parameter int ACC_W      = 8,
    parameter int SATURATE   = 1,
    parameter int LEAK_SHIFT = 0
) (
    input  logic signed [ACC_W-1:0] base,
    input  logic signed [IN_W-1:0]  in_data,
    output logic signed [ACC_W-1:0] result,
    output logic                    sat
);

    logic signed [ACC_W-1:0] leak;
    logic signed [ACC_W:0]   sum;
    logic                    ovf;

    // base - leak always fits ACC_W, so one extra bit holds the full sum.
    always_comb begin
        leak   = (LEAK_SHIFT > 0) ? (base >>> LEAK_SHIFT) : '0;
        sum    = (ACC_W+1)'(base) - (ACC_W+1)'(leak) + (ACC_W+1)'(in_data);
        ovf    = sum[ACC_W] != sum[ACC_W-1];
        sat    = (SATURATE != 0) && ovf;
        result = !sat ? sum[ACC_W-1:0]
               : sum[ACC_W] ? ACC_W'(sat_min(ACC_W)) : ACC_W'(sat_max(ACC_W));
    end

endmodule

// File: rtl/feedback_accum_multi.sv
// feedback_accum_multi: CHANNELS signed accumulators sharing one update path,
// with a registered valid/ready output stage.
module feedback_accum_multi
    import feedback_accum_pkg::*;
#(
    parameter int  IN_W       = 8,
    parameter int  ACC_W      = 8,
    parameter int  CHANNELS   = 4,
    parameter int  SATURATE   = 1,
    parameter int  LEAK_SHIFT = 0,
    localparam int CHAN_W     = chan_w(CHANNELS)
) (
    input  logic                    system1000,
    input  logic                    system1000_rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CHAN_W-1:0]       in_chan,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic                    clr,
    input  logic [CHAN_W-1:0]       clr_chan,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CHAN_W-1:0]       out_chan,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    out_sat
);

    typedef struct packed {
        logic [CHAN_W-1:0]       chan;
        logic signed [ACC_W-1:0] data;
        logic                    sat;
    } accum_result_t;

    logic signed [ACC_W-1:0] acc_q [CHANNELS];
    logic signed [ACC_W-1:0] acc_d [CHANNELS];
    accum_result_t           res_q, res_d;
    logic                    out_valid_q, out_valid_d;
    logic                    in_ok, clr_ok, take;
    logic signed [ACC_W-1:0] base, step_result;
    logic                    step_sat;

    assign in_ready = !out_valid_q || out_ready;
    assign in_ok    = {1'b0, in_chan} < (CHAN_W+1)'(CHANNELS);
    assign clr_ok   = {1'b0, clr_chan} < (CHAN_W+1)'(CHANNELS);
    assign take     = in_valid && in_ready && in_ok;
    // A same-cycle clear on the sampled channel wins over the stored value.
    assign base     = (!in_ok || (clr && clr_ok && clr_chan == in_chan)) ? '0 : acc_q[in_chan];

    feedback_accum_step #(
        .IN_W       (IN_W),
        .ACC_W      (ACC_W),
        .SATURATE   (SATURATE),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_step (
        .base    (base),
        .in_data (in_data),
        .result  (step_result),
        .sat     (step_sat)
    );

    always_comb begin
        acc_d       = acc_q;
        res_d       = res_q;
        out_valid_d = take || (out_valid_q && !out_ready);
        if (clr && clr_ok)
            acc_d[clr_chan] = '0;
        if (take) begin
            acc_d[in_chan] = step_result;
            res_d          = '{chan: in_chan, data: step_result, sat: step_sat};
        end
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            acc_q       <= '{default: '0};
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_chan  = res_q.chan;
    assign out_data  = res_q.data;
    assign out_sat   = res_q.sat;

endmodule
